// File: rtl/fetch_stage_pkg.sv
// Shared fetch-stage definitions: widths, reset/bubble words, state and action encodings,
// and the IF/ID pipeline register layout.
package fetch_stage_pkg;

  localparam int DATA_W = 16;

  localparam logic [3:0]        OP_NOP    = 4'hF;
  localparam logic [DATA_W-1:0] RESET_PC  = 16'h0000;
  // Bubble word must never decode as the all-zero halt opcode.
  localparam logic [DATA_W-1:0] NOP_INSTR = {OP_NOP, 12'h000};

  typedef enum logic {
    FS_RUN    = 1'b0,
    FS_HALTED = 1'b1
  } fetch_state_t;

  // What the current edge does to PC and IF/ID, already priority-resolved.
  typedef enum logic [2:0] {
    ACT_FETCH    = 3'd0,
    ACT_FLUSH    = 3'd1,
    ACT_STALL    = 3'd2,
    ACT_REDIRECT = 3'd3,
    ACT_HALT     = 3'd4,
    ACT_IDLE     = 3'd5
  } fetch_act_t;

  typedef struct packed {
    logic [DATA_W-1:0] instr;
    logic [DATA_W-1:0] pc_plus2;
    logic              valid;
  } ifid_t;

endpackage

// File: rtl/fetch_stage_pc_next_sel.sv
// Next-PC priority select: halted > halt > redirect > stall > flush > sequential fetch.
// Latency: purely combinational.
// Backpressure: stall holds PC; redirect overrides stall and flush.
module pc_next_sel
  import fetch_stage_pkg::*;
(
  input  logic [DATA_W-1:0] pc,
  input  logic              halted,
  input  logic              halt,
  input  logic              pc_op,
  input  logic              b_jmp,
  input  logic              stall,
  input  logic              if_flush,
  input  logic [DATA_W-1:0] branch_target,
  input  logic [DATA_W-1:0] jump_target,
  output logic [DATA_W-1:0] pc_next,
  output logic [DATA_W-1:0] pc_plus2,
  output logic [2:0]        act
);

  logic [DATA_W-1:0] target;

  assign pc_plus2 = pc + DATA_W'(2);
  assign target   = b_jmp ? branch_target : jump_target;

  always_comb begin
    pc_next = pc;
    act     = ACT_FETCH;
    if (halted) begin
      act = ACT_IDLE;
    end else if (halt) begin
      act = ACT_HALT;
    end else if (pc_op) begin
      act     = ACT_REDIRECT;
      pc_next = {target[DATA_W-1:1], 1'b0};
    end else if (stall) begin
      act = ACT_STALL;
    end else if (if_flush) begin
      act = ACT_FLUSH;
    end else begin
      pc_next = pc_plus2;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: owns PC, drives imem address, loads IF/ID; sticky HALTED until reset.
// Latency: imem word at cycle N appears on ifid_* after edge N; redirect visible next cycle.
// Backpressure: stall freezes PC, IF/ID and fetch_count; flush/redirect/halt insert a bubble.
module fetch_stage
  import fetch_stage_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  input  logic              pc_op,
  input  logic              b_jmp,
  input  logic              if_flush,
  input  logic              halt,
  input  logic [DATA_W-1:0] branch_target,
  input  logic [DATA_W-1:0] jump_target,
  output logic [DATA_W-1:0] imem_addr,
  input  logic [DATA_W-1:0] imem_rdata,
  output logic [DATA_W-1:0] ifid_instr,
  output logic [DATA_W-1:0] ifid_pc_plus2,
  output logic              ifid_valid,
  output logic              halted,
  output logic [15:0]       fetch_count
);

  fetch_state_t      state, state_next;
  logic [DATA_W-1:0] pc, pc_next, pc_plus2;
  logic [2:0]        act_raw;
  fetch_act_t        act;
  ifid_t             ifid;

  pc_next_sel u_pc_next_sel (
    .pc            (pc),
    .halted        (halted),
    .halt          (halt),
    .pc_op         (pc_op),
    .b_jmp         (b_jmp),
    .stall         (stall),
    .if_flush      (if_flush),
    .branch_target (branch_target),
    .jump_target   (jump_target),
    .pc_next       (pc_next),
    .pc_plus2      (pc_plus2),
    .act           (act_raw)
  );

  assign act    = fetch_act_t'(act_raw);
  assign halted = (state == FS_HALTED);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= FS_RUN;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    if (state == FS_RUN && halt) state_next = FS_HALTED;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc          <= RESET_PC;
      ifid        <= '{instr: NOP_INSTR, pc_plus2: '0, valid: 1'b0};
      fetch_count <= '0;
    end else begin
      pc <= pc_next;
      case (act)
        ACT_FETCH: begin
          ifid <= '{instr: imem_rdata, pc_plus2: pc_plus2, valid: 1'b1};
          if (fetch_count != 16'hFFFF) fetch_count <= fetch_count + 16'd1;
        end
        // Bubble keeps the stale pc_plus2; consumers qualify on valid.
        ACT_HALT, ACT_REDIRECT, ACT_FLUSH: begin
          ifid.instr <= NOP_INSTR;
          ifid.valid <= 1'b0;
        end
        default: ifid <= ifid;
      endcase
    end
  end

  assign imem_addr     = pc;
  assign ifid_instr    = ifid.instr;
  assign ifid_pc_plus2 = ifid.pc_plus2;
  assign ifid_valid    = ifid.valid;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed scenarios plus randomized traffic checked against a cycle-level reference model.
module tb_fetch_stage;

  logic        clk, reset, stall, pc_op, b_jmp, if_flush, halt;
  logic [15:0] branch_target, jump_target, imem_addr, imem_rdata;
  logic [15:0] ifid_instr, ifid_pc_plus2, fetch_count;
  logic        ifid_valid, halted;

  int n_checks = 0;
  int n_pass   = 0;

  // reference model state
  logic [15:0] m_pc, m_instr, m_pp2, m_count;
  logic        m_valid, m_halted;

  fetch_stage dut (
    .clk           (clk),
    .reset         (reset),
    .stall         (stall),
    .pc_op         (pc_op),
    .b_jmp         (b_jmp),
    .if_flush      (if_flush),
    .halt          (halt),
    .branch_target (branch_target),
    .jump_target   (jump_target),
    .imem_addr     (imem_addr),
    .imem_rdata    (imem_rdata),
    .ifid_instr    (ifid_instr),
    .ifid_pc_plus2 (ifid_pc_plus2),
    .ifid_valid    (ifid_valid),
    .halted        (halted),
    .fetch_count   (fetch_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [15:0] rom(input logic [15:0] a);
    logic [15:0] h;
    if (a == 16'h0000) return 16'h1234;
    if (a == 16'h0002) return 16'h2345;
    h = a * 16'h9E37;
    return h ^ 16'h5A5A;
  endfunction

  always_comb imem_rdata = rom(imem_addr);

  task automatic idle_inputs();
    stall = 0; pc_op = 0; b_jmp = 0; if_flush = 0; halt = 0;
    branch_target = 16'h0000; jump_target = 16'h0000;
  endtask

  task automatic model_reset();
    m_pc = 16'h0000; m_instr = 16'hF000; m_pp2 = 16'h0000;
    m_valid = 0; m_halted = 0; m_count = 16'h0000;
  endtask

  // Applies the documented per-edge rules to the model using the current inputs.
  task automatic model_edge();
    if (m_halted) return;
    if (halt) begin
      m_halted = 1; m_instr = 16'hF000; m_valid = 0;
    end else if (pc_op) begin
      m_pc = (b_jmp ? branch_target : jump_target) & 16'hFFFE;
      m_instr = 16'hF000; m_valid = 0;
    end else if (stall) begin
      // everything holds
    end else if (if_flush) begin
      m_instr = 16'hF000; m_valid = 0;
    end else begin
      m_instr = rom(m_pc);
      m_pp2   = m_pc + 16'd2;
      m_valid = 1;
      m_pc    = m_pp2;
      if (m_count != 16'hFFFF) m_count = m_count + 16'd1;
    end
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    idle_inputs();
    reset = 1;
    #2;
    reset = 0;
    model_reset();
  endtask

  task automatic redirect_to(input logic [15:0] a);
    idle_inputs();
    pc_op = 1; jump_target = a;
    tick();
    idle_inputs();
  endtask

  task automatic test_reset();
    @(posedge clk);
    #1;
    idle_inputs();
    reset = 1;
    #1;
    n_checks++;
    if ({imem_addr, ifid_instr, ifid_pc_plus2, ifid_valid, halted, fetch_count} !==
        {16'h0000, 16'hF000, 16'h0000, 1'b0, 1'b0, 16'h0000})
      $display("FAIL reset_state: addr=%h instr=%h pp2=%h v=%b h=%b cnt=%h, want 0000 f000 0000 0 0 0000",
               imem_addr, ifid_instr, ifid_pc_plus2, ifid_valid, halted, fetch_count);
    else n_pass++;
    #1;
    reset = 0;
    model_reset();
  endtask

  task automatic test_sequential();
    do_reset();
    tick();
    n_checks++;
    if ({ifid_instr, ifid_pc_plus2, ifid_valid, imem_addr} !== {16'h1234, 16'h0002, 1'b1, 16'h0002})
      $display("FAIL seq_first: instr=%h pp2=%h v=%b addr=%h, want 1234 0002 1 0002",
               ifid_instr, ifid_pc_plus2, ifid_valid, imem_addr);
    else n_pass++;
    tick();
    n_checks++;
    if ({ifid_instr, ifid_pc_plus2, ifid_valid, fetch_count} !== {16'h2345, 16'h0004, 1'b1, 16'd2})
      $display("FAIL seq_second: instr=%h pp2=%h v=%b cnt=%0d, want 2345 0004 1 2",
               ifid_instr, ifid_pc_plus2, ifid_valid, fetch_count);
    else n_pass++;
  endtask

  task automatic test_redirect_over_stall();
    do_reset();
    tick();
    stall = 1; if_flush = 1; pc_op = 1; b_jmp = 1;
    branch_target = 16'h0041; jump_target = 16'h0777;
    tick();
    idle_inputs();
    n_checks++;
    if ({imem_addr, ifid_valid, ifid_instr, fetch_count} !== {16'h0040, 1'b0, 16'hF000, 16'd1})
      $display("FAIL redirect_stall: addr=%h v=%b instr=%h cnt=%0d, want 0040 0 f000 1",
               imem_addr, ifid_valid, ifid_instr, fetch_count);
    else n_pass++;
    pc_op = 1; b_jmp = 0; branch_target = 16'h0100; jump_target = 16'h0123;
    tick();
    idle_inputs();
    n_checks++;
    if (imem_addr !== 16'h0122)
      $display("FAIL redirect_jump: addr=%h, want 0122", imem_addr);
    else n_pass++;
  endtask

  task automatic test_stall();
    do_reset();
    redirect_to(16'h000E);
    tick();
    for (int i = 0; i < 3; i++) begin
      stall = 1; if_flush = (i == 1);
      tick();
      n_checks++;
      if ({imem_addr, ifid_instr, ifid_pc_plus2, ifid_valid, fetch_count} !==
          {16'h0010, rom(16'h000E), 16'h0010, 1'b1, 16'd1})
        $display("FAIL stall_hold_%0d: addr=%h instr=%h pp2=%h v=%b cnt=%0d, want 0010 %h 0010 1 1",
                 i, imem_addr, ifid_instr, ifid_pc_plus2, ifid_valid, fetch_count, rom(16'h000E));
      else n_pass++;
    end
    idle_inputs();
    tick();
    n_checks++;
    if ({ifid_instr, ifid_pc_plus2, fetch_count} !== {rom(16'h0010), 16'h0012, 16'd2})
      $display("FAIL stall_resume: instr=%h pp2=%h cnt=%0d, want %h 0012 2",
               ifid_instr, ifid_pc_plus2, fetch_count, rom(16'h0010));
    else n_pass++;
  endtask

  task automatic test_wrap();
    do_reset();
    redirect_to(16'hFFFE);
    tick();
    n_checks++;
    if ({imem_addr, ifid_pc_plus2, ifid_instr, ifid_valid} !== {16'h0000, 16'h0000, rom(16'hFFFE), 1'b1})
      $display("FAIL pc_wrap: addr=%h pp2=%h instr=%h v=%b, want 0000 0000 %h 1",
               imem_addr, ifid_pc_plus2, ifid_instr, ifid_valid, rom(16'hFFFE));
    else n_pass++;
  endtask

  task automatic test_halt_and_reset();
    do_reset();
    tick();
    halt = 1;
    tick();
    halt = 0;
    n_checks++;
    if ({halted, imem_addr, ifid_valid, ifid_instr, fetch_count} !== {1'b1, 16'h0002, 1'b0, 16'hF000, 16'd1})
      $display("FAIL halt_enter: h=%b addr=%h v=%b instr=%h cnt=%0d, want 1 0002 0 f000 1",
               halted, imem_addr, ifid_valid, ifid_instr, fetch_count);
    else n_pass++;
    for (int i = 0; i < 4; i++) begin
      pc_op = i[0]; if_flush = ~i[0]; b_jmp = i[1]; jump_target = 16'h0300; branch_target = 16'h0500;
      tick();
      n_checks++;
      if ({halted, imem_addr, ifid_valid, fetch_count} !== {1'b1, 16'h0002, 1'b0, 16'd1})
        $display("FAIL halt_sticky_%0d: h=%b addr=%h v=%b cnt=%0d, want 1 0002 0 1",
                 i, halted, imem_addr, ifid_valid, fetch_count);
      else n_pass++;
    end
    idle_inputs();
    // asynchronous reset asserted between edges must clear everything before the next edge
    #2;
    reset = 1;
    #1;
    n_checks++;
    if ({halted, imem_addr, ifid_valid, ifid_instr, fetch_count} !== {1'b0, 16'h0000, 1'b0, 16'hF000, 16'd0})
      $display("FAIL async_reset: h=%b addr=%h v=%b instr=%h cnt=%0d, want 0 0000 0 f000 0",
               halted, imem_addr, ifid_valid, ifid_instr, fetch_count);
    else n_pass++;
    @(posedge clk);
    #1;
    reset = 0;
    model_reset();
    tick();
    n_checks++;
    if ({ifid_instr, ifid_valid, halted, fetch_count} !== {16'h1234, 1'b1, 1'b0, 16'd1})
      $display("FAIL post_reset_fetch: instr=%h v=%b h=%b cnt=%0d, want 1234 1 0 1",
               ifid_instr, ifid_valid, halted, fetch_count);
    else n_pass++;
  endtask

  task automatic test_flush();
    do_reset();
    redirect_to(16'h0008);
    tick();
    if_flush = 1;
    tick();
    if_flush = 0;
    n_checks++;
    if ({ifid_valid, ifid_instr, imem_addr, fetch_count} !== {1'b0, 16'hF000, 16'h000A, 16'd1})
      $display("FAIL flush_bubble: v=%b instr=%h addr=%h cnt=%0d, want 0 f000 000a 1",
               ifid_valid, ifid_instr, imem_addr, fetch_count);
    else n_pass++;
    tick();
    n_checks++;
    if ({ifid_instr, ifid_pc_plus2, ifid_valid, fetch_count} !== {rom(16'h000A), 16'h000C, 1'b1, 16'd2})
      $display("FAIL flush_refetch: instr=%h pp2=%h v=%b cnt=%0d, want %h 000c 1 2",
               ifid_instr, ifid_pc_plus2, ifid_valid, fetch_count, rom(16'h000A));
    else n_pass++;
  endtask

  task automatic test_random();
    int errs;
    errs = 0;
    do_reset();
    for (int i = 0; i < 800; i++) begin
      halt          = ($urandom_range(0, 99) == 0);
      pc_op         = ($urandom_range(0, 5) == 0);
      b_jmp         = $urandom_range(0, 1) == 1;
      stall         = ($urandom_range(0, 3) == 0);
      if_flush      = ($urandom_range(0, 5) == 0);
      branch_target = 16'($urandom);
      jump_target   = 16'($urandom);
      if ($urandom_range(0, 59) == 0) do_reset();
      else tick();
      n_checks++;
      if ({imem_addr, ifid_instr, ifid_pc_plus2, ifid_valid, halted, fetch_count} !==
          {m_pc, m_instr, m_pp2, m_valid, m_halted, m_count}) begin
        if (errs < 10)
          $display("FAIL random_%0d: addr=%h instr=%h pp2=%h v=%b h=%b cnt=%h, want %h %h %h %b %b %h",
                   i, imem_addr, ifid_instr, ifid_pc_plus2, ifid_valid, halted, fetch_count,
                   m_pc, m_instr, m_pp2, m_valid, m_halted, m_count);
        errs++;
      end else n_pass++;
    end
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    reset = 1;
    model_reset();
    test_reset();
    test_sequential();
    test_redirect_over_stall();
    test_stall();
    test_wrap();
    test_halt_and_reset();
    test_flush();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, checks passed %0d of %0d", n_pass, n_checks);
    $fatal(1);
  end

endmodule
